// File: rtl/clk_enable_gen.sv
// clk_enable_gen
// Multi-channel clock divider / enable generator for the display,
// seven-segment and game-logic timing domains. Each channel counts master
// clock cycles up to its divisor and toggles a 50%-duty divided clock at
// every terminal count, with a one-cycle tick per toggle and a one-cycle
// rise strobe per 0->1 toggle.
//
// Optional feature macro: CLKGEN_LOAD_EN
//   defined   : divisors are reloadable through ld_valid/ld_ready/ld_ch/ld_div.
//               A load waits in a single pending slot until the target
//               channel's next terminal count (or a sync).
//   undefined : divisors are fixed to DIV_INIT, the load inputs are ignored
//               and ld_ready is tied low.
//
// Ports
//   clk      in   master clock
//   clr      in   asynchronous active-high reset
//   en       in   per-channel count enable
//   sync     in   synchronous restart of all channels (beats en)
//   ld_valid in   divisor load request
//   ld_ready out  pending slot free
//   ld_ch    in   load target channel (values >= NCH are accepted and dropped)
//   ld_div   in   new divisor
//   clk_out  out  divided clocks, half-period = div+1 cycles
//   tick     out  one-cycle pulse coincident with each clk_out toggle
//   rise     out  one-cycle pulse coincident with each clk_out 0->1 toggle
module clk_enable_gen #(
  parameter int NCH = 3,
  parameter int CW = 28,
  parameter logic [NCH*CW-1:0] DIV_INIT = {28'd10, 28'd10, 28'd4},
  localparam int LCW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [NCH-1:0] en,
  input  logic           sync,
  input  logic           ld_valid,
  output logic           ld_ready,
  input  logic [LCW-1:0] ld_ch,
  input  logic [CW-1:0]  ld_div,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] rise
);

  logic [CW-1:0]  cnt [NCH];
  logic [CW-1:0]  div [NCH];
  logic [NCH-1:0] term;

  // A channel is at terminal count when its counter has reached the active
  // divisor; cnt never passes div because a new divisor lands with cnt=0.
  always_comb begin
    term = '0;
    for (int k = 0; k < NCH; k++) begin
      term[k] = (cnt[k] == div[k]);
    end
  end

  // Per-channel counter and output registers. sync restarts everything in
  // phase; a disabled channel freezes its count and output level.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int k = 0; k < NCH; k++) begin
        cnt[k] <= '0;
      end
      clk_out <= '0;
      tick    <= '0;
      rise    <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (sync) begin
          cnt[k]     <= '0;
          clk_out[k] <= 1'b0;
          tick[k]    <= 1'b0;
          rise[k]    <= 1'b0;
        end else if (en[k] && term[k]) begin
          cnt[k]     <= '0;
          clk_out[k] <= ~clk_out[k];
          tick[k]    <= 1'b1;
          rise[k]    <= ~clk_out[k];
        end else if (en[k]) begin
          cnt[k]  <= cnt[k] + CW'(1);
          tick[k] <= 1'b0;
          rise[k] <= 1'b0;
        end else begin
          tick[k] <= 1'b0;
          rise[k] <= 1'b0;
        end
      end
    end
  end

`ifdef CLKGEN_LOAD_EN
  logic           pend_valid;
  logic [LCW-1:0] pend_ch;
  logic [CW-1:0]  pend_div;
  logic [NCH-1:0] apply_vec;
  logic           slot_free;
  logic           accept;

  // The pending divisor lands either at its channel's terminal edge (so the
  // half-period in progress finishes on the old divisor) or at a sync.
  always_comb begin
    apply_vec = '0;
    for (int k = 0; k < NCH; k++) begin
      apply_vec[k] = pend_valid && (pend_ch == LCW'(k)) &&
                     (sync || (en[k] && term[k]));
    end
  end

  assign slot_free = |apply_vec;
  assign ld_ready  = ~pend_valid;
  // Out-of-range channels complete the handshake but never occupy the slot.
  assign accept    = ld_valid && ld_ready && (int'(ld_ch) < NCH);

  // Divisor registers and the single pending slot. Acceptance needs an empty
  // slot, so it can never coincide with the slot being freed; a load taken
  // on a sync edge is therefore stored rather than applied.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int k = 0; k < NCH; k++) begin
        div[k] <= DIV_INIT[k*CW +: CW];
      end
      pend_valid <= 1'b0;
      pend_ch    <= '0;
      pend_div   <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (apply_vec[k]) begin
          div[k] <= pend_div;
        end
      end
      if (accept) begin
        pend_valid <= 1'b1;
        pend_ch    <= ld_ch;
        pend_div   <= ld_div;
      end else if (slot_free) begin
        pend_valid <= 1'b0;
      end
    end
  end
`else
  for (genvar k = 0; k < NCH; k++) begin : g_fixed_div
    assign div[k] = DIV_INIT[k*CW +: CW];
  end

  assign ld_ready = 1'b0;

  logic unused_load;
  assign unused_load = &{1'b0, ld_valid, ld_ch, ld_div};
`endif

endmodule

// File: tb/tb_clk_enable_gen.sv
// Testbench for clk_enable_gen (NCH=3, CW=28, DIV_INIT {10,10,4}).
// Every cycle the stimulus task advances a behavioural model of the divider,
// queues the expected {clk_out, tick, rise, ld_ready} and compares it with
// the DUT a moment after the clock edge. Directed load scenarios are built
// only when CLKGEN_LOAD_EN is defined, matching the DUT build.
module tb_clk_enable_gen;

`ifdef CLKGEN_LOAD_EN
  localparam bit LOAD = 1'b1;
`else
  localparam bit LOAD = 1'b0;
`endif

  logic        clk;
  logic        clr;
  logic [2:0]  en;
  logic        sync;
  logic        ld_valid;
  logic        ld_ready;
  logic [1:0]  ld_ch;
  logic [27:0] ld_div;
  logic [2:0]  clk_out;
  logic [2:0]  tick;
  logic [2:0]  rise;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [9:0] expq [$];

  logic [27:0] m_cnt [3];
  logic [27:0] m_div [3];
  logic [2:0]  m_clk, m_tick, m_rise;
  bit          m_pv;
  logic [1:0]  m_pch;
  logic [27:0] m_pdiv;

  clk_enable_gen #(
    .NCH(3),
    .CW(28),
    .DIV_INIT({28'd10, 28'd10, 28'd4})
  ) dut (
    .clk(clk),
    .clr(clr),
    .en(en),
    .sync(sync),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_ch(ld_ch),
    .ld_div(ld_div),
    .clk_out(clk_out),
    .tick(tick),
    .rise(rise)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Behavioural divider model: one clock edge with the currently driven inputs.
  task automatic modelStep();
    bit   ready_now;
    bit   freed;
    logic [27:0] n_div [3];
    ready_now = LOAD && !m_pv;
    freed = 0;
    for (int k = 0; k < 3; k++) n_div[k] = m_div[k];
    for (int k = 0; k < 3; k++) begin
      if (sync) begin
        m_cnt[k] = '0; m_clk[k] = 0; m_tick[k] = 0; m_rise[k] = 0;
      end else if (!en[k]) begin
        m_tick[k] = 0; m_rise[k] = 0;
      end else if (m_cnt[k] != m_div[k]) begin
        m_cnt[k] = m_cnt[k] + 28'd1; m_tick[k] = 0; m_rise[k] = 0;
      end else begin
        m_cnt[k]  = '0;
        m_rise[k] = ~m_clk[k];
        m_clk[k]  = ~m_clk[k];
        m_tick[k] = 1;
        if (LOAD && m_pv && m_pch == 2'(k)) begin
          n_div[k] = m_pdiv;
          freed = 1;
        end
      end
    end
    if (LOAD && sync && m_pv) begin
      n_div[m_pch] = m_pdiv;
      freed = 1;
    end
    for (int k = 0; k < 3; k++) m_div[k] = n_div[k];
    if (freed) m_pv = 0;
    if (ready_now && ld_valid && ld_ch < 2'd3) begin
      m_pv = 1; m_pch = ld_ch; m_pdiv = ld_div;
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [2:0] e, input logic s,
                               input logic lv, input logic [1:0] lc, input logic [27:0] ld);
    logic [9:0] expv;
    en = e; sync = s; ld_valid = lv; ld_ch = lc; ld_div = ld;
    modelStep();
    expq.push_back({m_clk, m_tick, m_rise, LOAD && !m_pv});
    @(posedge clk);
    #1;
    cyc++;
    expv = expq.pop_front();
    checkOutput(tag, {22'd0, clk_out, tick, rise, ld_ready}, {22'd0, expv});
  endtask

  task automatic run(input string tag, input int n, input logic [2:0] e);
    for (int i = 0; i < n; i++) applyStimulus(tag, e, 1'b0, 1'b0, 2'd0, 28'd0);
  endtask

  initial begin
    int first0, first1, ticks0;
    clr = 1'b1; en = '0; sync = 0; ld_valid = 0; ld_ch = '0; ld_div = '0;
    m_cnt[0] = 0; m_cnt[1] = 0; m_cnt[2] = 0;
    m_div[0] = 28'd4; m_div[1] = 28'd10; m_div[2] = 28'd10;
    m_clk = 0; m_tick = 0; m_rise = 0; m_pv = 0; m_pch = 0; m_pdiv = 0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", {22'd0, clk_out, tick, rise, ld_ready}, {31'd0, LOAD});
    clr = 1'b0;

    // Free-running from reset release: ch0 D=4, ch1/ch2 D=10.
    first0 = 0; first1 = 0; ticks0 = 0;
    for (int i = 1; i <= 30; i++) begin
      applyStimulus("run", 3'b111, 1'b0, 1'b0, 2'd0, 28'd0);
      if (rise[0] && first0 == 0) first0 = i;
      if (rise[1] && first1 == 0) first1 = i;
      if (tick[0]) ticks0++;
    end
    checkOutput("rise0_edge", 32'(first0), 32'd5);
    checkOutput("rise1_edge", 32'(first1), 32'd11);
    checkOutput("tick0_count", 32'(ticks0), 32'd6);

`ifdef CLKGEN_LOAD_EN
    // Load ch0 div=1 mid half-period.
    run("pre_ld0", 2, 3'b111);
    applyStimulus("ld0", 3'b111, 1'b0, 1'b1, 2'd0, 28'd1);
    run("post_ld0", 14, 3'b111);

    // Out-of-range channel: accepted and dropped.
    applyStimulus("ld_bad", 3'b111, 1'b0, 1'b1, 2'd3, 28'd7);
    run("post_bad", 3, 3'b111);

    // ch1 load pending when sync arrives.
    applyStimulus("ld1", 3'b111, 1'b0, 1'b1, 2'd1, 28'd2);
    run("pend1", 3, 3'b111);
    applyStimulus("sync_pend", 3'b111, 1'b1, 1'b0, 2'd0, 28'd0);
    checkOutput("sync_clk", {29'd0, clk_out}, 32'd0);
    run("post_sync", 12, 3'b111);

    // Load accepted on a sync edge is stored, not applied.
    applyStimulus("sync_ld", 3'b111, 1'b1, 1'b1, 2'd2, 28'd3);
    run("post_sync_ld", 12, 3'b111);

    // div=0 on ch0: toggles every cycle with tick held high.
    applyStimulus("ld0_zero", 3'b111, 1'b0, 1'b1, 2'd0, 28'd0);
    run("div0", 12, 3'b111);
    checkOutput("div0_tick", {31'd0, tick[0]}, 32'd1);
    applyStimulus("ld0_back", 3'b111, 1'b0, 1'b1, 2'd0, 28'd4);
    run("restore", 6, 3'b111);
`endif

    // ch2 disabled for 7 cycles, then resumes from its held count.
    run("en2_off", 7, 3'b011);
    run("en2_on", 10, 3'b111);

    // Sync at an arbitrary phase.
    run("pre_sync", 3, 3'b111);
    applyStimulus("sync", 3'b111, 1'b1, 1'b0, 2'd0, 28'd0);
    checkOutput("sync_zero", {29'd0, clk_out}, 32'd0);
    run("aligned", 15, 3'b111);

    // Random mix of enables, syncs and loads.
    for (int i = 0; i < 300; i++) begin
      logic [2:0] e;
      e[0] = ($urandom_range(0, 7) != 0);
      e[1] = ($urandom_range(0, 7) != 0);
      e[2] = ($urandom_range(0, 7) != 0);
      applyStimulus("rand", e, ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
                    28'($urandom_range(0, 6)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
